// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Return-address predictor stack. A retiring jal pushes its link value (PC+4)
// and a retiring jr r31 pops it. The stack is a circular buffer: when a push
// arrives while full, the oldest entry is silently overwritten by wrap-around,
// which keeps the most recent call chain usable.
//
// Parameters
//   DEPTH      number of entries, a power of two from 2 to 32
//   AW         return-address width
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset (priority over everything)
//   flush      empties the stack (mispredict / exception recovery)
//   push       push request, push_addr is the value stored
//   push_addr  link value to store, all AW bits kept
//   pop        pop request
//   top_addr   predicted return address, zero while empty
//   top_valid  stack holds at least one entry
//   count      current occupancy, 0..DEPTH
//   overflow   one-cycle pulse after a push that discarded the oldest entry
//   underflow  one-cycle pulse after a pop requested while empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic                     pop,
  output logic [AW-1:0]            top_addr,
  output logic                     top_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tos;

  logic [PW-1:0] tos_next;
  logic [CW-1:0] count_next;
  logic          overflow_next;
  logic          underflow_next;
  logic          wr_en;
  logic [PW-1:0] wr_ptr;

  logic empty;
  logic full;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Next-state decode. Flush beats push/pop; reset is applied in the register.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    tos_next       = tos;
    count_next     = count;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    wr_en          = 1'b0;
    wr_ptr         = tos + PW'(1);

    if (flush) begin
      tos_next   = '0;
      count_next = '0;
    end else if (push && pop && !empty) begin
      // Return then call in the same cycle: replace the top in place.
      wr_en  = 1'b1;
      wr_ptr = tos;
    end else if (push) begin
      // Also covers push+pop while empty, which behaves as a plain push.
      wr_en    = 1'b1;
      tos_next = tos + PW'(1);
      if (full) begin
        overflow_next = 1'b1;
      end else begin
        count_next = count + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        underflow_next = 1'b1;
      end else begin
        tos_next   = tos - PW'(1);
        count_next = count - CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tos       <= tos_next;
      count     <= count_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  // NOTE: the array is deliberately not reset; its contents are unobservable
  // while count is zero, and leaving it out lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= push_addr;
    end
  end

  assign top_valid = !empty;
  assign top_addr  = empty ? '0 : mem[tos];

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of stack entries; legal values are powers of two from 2 to 32.
REQ-002 Parameter AW, default 32, SHALL set the return-address width.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port flush, input, 1 bit, SHALL empty the stack (mispredict or exception recovery).
REQ-006 Port push, input, 1 bit, SHALL request a push (jal retiring; its write register is 31).
REQ-007 Port push_addr, input, AW bits, SHALL be the link value written by jal (PC+4).
REQ-008 Port pop, input, 1 bit, SHALL request a pop (jr retiring with rs = 31).
REQ-009 Port top_addr, output, AW bits, SHALL be the predicted return address.
REQ-010 Port top_valid, output, 1 bit, SHALL be high when the stack holds at least one entry.
REQ-011 Port count, output, log2(DEPTH)+1 bits, SHALL be the current occupancy, 0..DEPTH.
REQ-012 Port overflow, output, 1 bit, SHALL be a one-cycle pulse when a push discards the oldest entry.
REQ-013 Port underflow, output, 1 bit, SHALL be a one-cycle pulse when a pop is requested while empty.

Function
REQ-014 Storage SHALL be a circular array of DEPTH x AW entries with a log2(DEPTH)-bit top-of-stack pointer tos and an occupancy counter.
REQ-015 top_addr SHALL equal mem[tos] when count > 0 and all-zero when count = 0; it is combinational from registered state only, with no input-to-output path.
REQ-016 top_valid SHALL equal (count != 0).
REQ-017 Push only: tos advances by 1 modulo DEPTH, mem[new tos] <= push_addr, and count increments saturating at DEPTH; the new value is visible on top_addr the cycle after the push.
REQ-018 Push while count = DEPTH: the oldest entry is overwritten through wrap-around, count stays DEPTH, and overflow pulses high the next cycle.
REQ-019 Pop only with count > 0: tos retreats by 1 modulo DEPTH and count decrements; the popped entry is not cleared.
REQ-020 Pop only with count = 0: no state change, and underflow pulses high the next cycle.
REQ-021 Push and pop in the same cycle with count > 0: mem[tos] <= push_addr, while tos and count are unchanged; no pulses.
REQ-022 Push and pop in the same cycle with count = 0: treated as push only (count becomes 1); no underflow.
REQ-023 Flush: count <= 0 and tos <= 0; flush has priority over push and pop in the same cycle; no pulses.
REQ-024 push_addr SHALL be stored unmodified at all AW bits, including the low 2 bits.
REQ-025 overflow and underflow SHALL be registered and high for exactly one cycle per causing event.
REQ-026 Priority SHALL be reset > flush > push/pop.

Reset
REQ-027 While reset is high at a clock edge: count = 0, tos = 0, overflow = 0, underflow = 0; therefore top_valid = 0 and top_addr = 0 on the following cycle.
REQ-028 Array contents SHALL NOT be reset; they are unobservable while count = 0.
REQ-029 Reset asserted mid-sequence (for example with push high) SHALL discard that cycle's push or pop.

Verification
REQ-030 After reset, push 0x00400010 then 0x00400020 -> top_addr = 0x00400020 and count = 2; pop -> top_addr = 0x00400010 and count = 1; pop -> top_valid = 0 and top_addr = 0.
REQ-031 DEPTH=8: push 0x100, 0x104, ..., 0x120 (9 pushes) -> overflow pulses once, on the cycle after the 9th push; count = 8; 8 pops return 0x120 down to 0x104; the 9th pop pulses underflow.
REQ-032 Empty stack: pop -> underflow = 1 for one cycle, count stays 0; push and pop together -> count = 1, top_addr = push_addr, underflow = 0.
REQ-033 count = 3, top = 0xA0: push and pop together with 0xB0 -> count = 3, top_addr = 0xB0; pop -> the second entry is exposed unchanged.
REQ-034 count = 5, with flush, push and pop all high -> count = 0 and top_valid = 0 next cycle; a subsequent push of 0xC0 -> count = 1, top_addr = 0xC0.
REQ-035 Reset asserted for one cycle together with push 0xD0 at count = 4 -> count = 0, top_addr = 0, no pulses.
